blend_rmw_pipe: RTL and testbench
=================================

// Module: blend_rmw_pipe
// PURPOSE
//  Read-modify-write back end for semi-transparent fragments. Accepts one RGB888 fragment,
//  fetches the destination VRAM pixel (16-bit, 1555) when needed, expands it to 8-bit, and blends it
//  with the PSX B/F equations. It then applies the mask-bit rules and issues the packed
//  1555 write to VRAM. Sits between the rasterizer fragment output and the VRAM arbiter.
// PARAMETERS
//  ADDRW   19  VRAM halfword address width (1024x512 pixels; x=addr[9:0], y=addr[18:10])
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active-high
//  frag_valid   in   1      fragment present
//  frag_ready   out  1      block can accept a fragment (1 only in IDLE)
//  frag_addr    in   ADDRW  destination pixel address
//  frag_r/g/b   in   8 ea.  fragment colour
//  frag_semi    in   1      1 = blend with background, 0 = opaque
//  frag_stmask  in   1      fragment mask bit (bit15 source)
//  blend_mode   in   2      0=(B+F)/2 1=B+F 2=B-F 3=B+F/4, sampled at accept
//  check_mask   in   1      1 = do not overwrite pixels whose bit15 is set
//  force_mask   in   1      1 = force bit15 of written pixel to 1
//  rd_req       out  1      read request, held until rd_ack
//  rd_addr      out  ADDRW  read address
//  rd_ack       in   1      read request accepted
//  rd_valid     in   1      read data valid (sampled only in RD_WAIT)
//  rd_data      in   16     background pixel {m,b5,g5,r5}
//  wr_req       out  1      write request, held until wr_ack
//  wr_addr      out  ADDRW  write address
//  wr_data      out  16     packed pixel {m,b5,g5,r5}
//  wr_ack       in   1      write accepted
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; rd_req=wr_req=0; rd_addr=wr_addr=0; wr_data=0; busy=0; frag_ready=0
//    while rst is high, 1 from the first cycle after release. Reset mid-operation abandons the
//    fragment; late rd_valid/wr_ack are ignored.
//  - Accept on clk edge with frag_valid&&frag_ready. All fragment fields and control inputs are
//    registered. need_rd = frag_semi|check_mask.
//  - FSM: IDLE -> RD_REQ if need_rd, else BLEND.
//    RD_REQ: rd_req=1, rd_addr stable; rd_ack -> RD_WAIT.
//    RD_WAIT: capture rd_data on rd_valid -> BLEND. rd_valid is never asserted in the rd_ack cycle.
//    BLEND (1 cycle): if check_mask && bg[15] -> IDLE with no write (discard). Else register
//    wr_data/wr_addr -> WR_REQ.
//    WR_REQ: wr_req=1, outputs stable; wr_ack -> IDLE.
//  - Latency, zero wait states: opaque gives wr_req 2 cycles after accept. Read path gives
//    wr_req 2 cycles after rd_valid. Exactly one write per non-discarded fragment.
//  - Expansion: B8 = {c5,3'b000} per channel.
//  - Blend: 10-bit signed per channel. mode0 (B+F)>>1; mode1 B+F; mode2 B-F; mode3 B+(F>>2).
//    Clamp to 0..255.
//  - Opaque (frag_semi=0): channel = F, no blend; bg is used only for the mask check.
//  - Pack: c5 = c8[7:3]; wr_data = {force_mask|frag_stmask, b5, g5, r5}.
// CONFIGURATION
//  BLEND_RMW_DITHER_EN defined:
//    - Add the PSX 4x4 ordered dither offset before pack and re-clamp 0..255.
//    - Offset is in -4..+3, indexed by {frag_addr[11:10], frag_addr[1:0]}.
//    - Rows: (-4,0,-3,1) (2,-2,3,-1) (-3,1,-4,0) (3,-1,2,-2).
//  BLEND_RMW_DITHER_EN undefined:
//    - Plain truncation. Timing and latency are identical in both builds.
// TESTING
//  1 reset: assert rst mid-RD_WAIT -> all outputs 0 at once. frag_ready=1 one cycle after release.
//  2 opaque: semi=0 check=0 force=0 stmask=0 rgb=FF/80/08 addr=0x00403 -> no rd_req.
//    wr_req 2 cycles later, wr_addr=0x00403, wr_data=0x061F.
//  3 additive: mode1 semi=1, bg=0x3DEF, rgb=C8/64/00 -> wr_data=0x3F7F (R clamped to 31).
//  4 subtract: mode2, bg=0x3DEF, rgb=C8/C8/C8, force_mask=1 -> wr_data=0x8000 (floor at 0).
//  5 mask check: check_mask=1, semi=0, bg=0x8000 -> no wr_req; frag_ready=1 two cycles after
//    rd_valid.
//  6 backpressure: rd_ack low 5 cycles, then wr_ack low 3 cycles -> rd_req/rd_addr and
//    wr_req/wr_addr/wr_data stay stable. frag_ready=0 throughout; one write only.

Source files
------------

// File: rtl/blend_rmw_pipe.sv
// ---------------------------------------------------------------------------
// blend_rmw_pipe
//   Read-modify-write back end for semi-transparent fragments. Accepts one
//   RGB888 fragment, optionally fetches the 1555 destination pixel, blends it
//   with the PSX B/F equations, applies the mask-bit rules and issues the
//   packed 1555 write to VRAM.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   frag_valid/frag_ready    fragment handshake (ready only in IDLE)
//   frag_addr, frag_r/g/b    destination address and fragment colour
//   frag_semi, frag_stmask   blend enable, fragment mask bit
//   blend_mode               0=(B+F)/2 1=B+F 2=B-F 3=B+F/4
//   check_mask, force_mask   preserve masked pixels / force written bit15
//   rd_req/rd_addr/rd_ack    background read request channel
//   rd_valid/rd_data         background read data {m,b5,g5,r5}
//   wr_req/wr_addr/wr_data   packed pixel write request {m,b5,g5,r5}
//   wr_ack                   write accepted
//   busy                     fragment in flight
//
// Build option
//   BLEND_RMW_DITHER_EN : add the PSX 4x4 ordered dither before packing.
//   Undefined: plain truncation. Latency is identical in both builds.
// ---------------------------------------------------------------------------
module blend_rmw_pipe #(
  parameter int ADDRW = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frag_valid,
  output logic             frag_ready,
  input  logic [ADDRW-1:0] frag_addr,
  input  logic [7:0]       frag_r,
  input  logic [7:0]       frag_g,
  input  logic [7:0]       frag_b,
  input  logic             frag_semi,
  input  logic             frag_stmask,
  input  logic [1:0]       blend_mode,
  input  logic             check_mask,
  input  logic             force_mask,
  output logic             rd_req,
  output logic [ADDRW-1:0] rd_addr,
  input  logic             rd_ack,
  input  logic             rd_valid,
  input  logic [15:0]      rd_data,
  output logic             wr_req,
  output logic [ADDRW-1:0] wr_addr,
  output logic [15:0]      wr_data,
  input  logic             wr_ack,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, BLEND, WR_REQ} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic [ADDRW-1:0] addr_p0;
  logic [7:0]       r_p0, g_p0, b_p0;
  logic             semi_p0, stmask_p0, check_p0, force_p0;
  logic [1:0]       mode_p0;
  logic [15:0]      bg_p1;
  logic [7:0]       r8_p1, g8_p1, b8_p1;
  logic [15:0]      pix_p1;
  logic             discard_p1;

  function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
    if (v < 10'sd0)
      return 8'd0;
    else if (v > 10'sd255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

  // 10-bit signed arithmetic leaves headroom for B+F (max 510) and B-F (min -255).
  function automatic logic signed [9:0] blend_ch(input logic [7:0] bg8, input logic [7:0] f8,
                                                 input logic [1:0] mode);
    logic signed [9:0] b;
    logic signed [9:0] f;
    b = signed'({2'b00, bg8});
    f = signed'({2'b00, f8});
    case (mode)
      2'd0:    return (b + f) >>> 1;
      2'd1:    return b + f;
      2'd2:    return b - f;
      default: return b + (f >>> 2);
    endcase
  endfunction

  // Opaque fragments pass the foreground straight through; the background is
  // then only consulted for the mask check.
  function automatic logic [7:0] chan(input logic [7:0] f8, input logic [4:0] bg5,
                                      input logic semi, input logic [1:0] mode);
    logic signed [9:0] v;
    v = semi ? blend_ch({bg5, 3'b000}, f8, mode) : signed'({2'b00, f8});
    return sat_u8(v);
  endfunction

`ifdef BLEND_RMW_DITHER_EN
  // Row = y[1:0] (addr[11:10]), column = x[1:0] (addr[1:0]).
  function automatic logic signed [3:0] dither_off(input logic [1:0] y, input logic [1:0] x);
    case ({y, x})
      4'h0: return -4'sd4;  4'h1: return  4'sd0;  4'h2: return -4'sd3;  4'h3: return  4'sd1;
      4'h4: return  4'sd2;  4'h5: return -4'sd2;  4'h6: return  4'sd3;  4'h7: return -4'sd1;
      4'h8: return -4'sd3;  4'h9: return  4'sd1;  4'hA: return -4'sd4;  4'hB: return  4'sd0;
      4'hC: return  4'sd3;  4'hD: return -4'sd1;  4'hE: return  4'sd2;  default: return -4'sd2;
    endcase
  endfunction

  function automatic logic [7:0] dither_apply(input logic [7:0] c8, input logic signed [3:0] d);
    logic signed [9:0] s;
    s = signed'({2'b00, c8}) + signed'({{6{d[3]}}, d});
    return sat_u8(s);
  endfunction
`endif

  assign accept = frag_valid && frag_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt  = state;
    frag_ready = 1'b0;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        frag_ready = !rst;
        busy       = 1'b0;
        if (accept)
          state_nxt = (frag_semi || check_mask) ? RD_REQ : BLEND;
      end
      RD_REQ: begin
        rd_req = 1'b1;
        if (rd_ack)
          state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_valid)
          state_nxt = BLEND;
      end
      BLEND: begin
        state_nxt = discard_p1 ? IDLE : WR_REQ;
      end
      WR_REQ: begin
        wr_req = 1'b1;
        if (wr_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: fragment capture. The address is visible on rd_addr, so it resets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (accept)
        addr_p0 <= frag_addr;
      if (state == BLEND) begin
        wr_addr <= addr_p0;
        wr_data <= pix_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      r_p0      <= frag_r;
      g_p0      <= frag_g;
      b_p0      <= frag_b;
      semi_p0   <= frag_semi;
      stmask_p0 <= frag_stmask;
      mode_p0   <= blend_mode;
      check_p0  <= check_mask;
      force_p0  <= force_mask;
    end
    if (state == RD_WAIT && rd_valid)
      bg_p1 <= rd_data;
  end

  assign rd_addr = addr_p0;

  // Stage p1: blend, optional dither, pack
  always_comb begin
    r8_p1 = chan(r_p0, bg_p1[4:0],   semi_p0, mode_p0);
    g8_p1 = chan(g_p0, bg_p1[9:5],   semi_p0, mode_p0);
    b8_p1 = chan(b_p0, bg_p1[14:10], semi_p0, mode_p0);
`ifdef BLEND_RMW_DITHER_EN
    r8_p1 = dither_apply(r8_p1, dither_off(addr_p0[11:10], addr_p0[1:0]));
    g8_p1 = dither_apply(g8_p1, dither_off(addr_p0[11:10], addr_p0[1:0]));
    b8_p1 = dither_apply(b8_p1, dither_off(addr_p0[11:10], addr_p0[1:0]));
`endif
    pix_p1 = {force_p0 | stmask_p0, 5'(b8_p1 >> 3), 5'(g8_p1 >> 3), 5'(r8_p1 >> 3)};
    // check_mask always forces a read, so bg_p1 is fresh whenever it matters.
    discard_p1 = check_p0 && bg_p1[15];
  end

endmodule

// File: tb/tb_blend_rmw_pipe.sv
// ---------------------------------------------------------------------------
// tb_blend_rmw_pipe
//   Directed, table-driven bench for blend_rmw_pipe (default build). Each
//   record holds a fragment, the background returned by the read, and the
//   expected write (or discard). Hand sequences cover reset mid-read and
//   read/write backpressure.
// ---------------------------------------------------------------------------
module tb_blend_rmw_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        frag_valid;
  logic        frag_ready;
  logic [18:0] frag_addr;
  logic [7:0]  frag_r, frag_g, frag_b;
  logic        frag_semi, frag_stmask;
  logic [1:0]  blend_mode;
  logic        check_mask, force_mask;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic        rd_ack, rd_valid;
  logic [15:0] rd_data;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  blend_rmw_pipe #(.ADDRW(19)) dut (
    .clk(clk), .rst(rst),
    .frag_valid(frag_valid), .frag_ready(frag_ready), .frag_addr(frag_addr),
    .frag_r(frag_r), .frag_g(frag_g), .frag_b(frag_b),
    .frag_semi(frag_semi), .frag_stmask(frag_stmask), .blend_mode(blend_mode),
    .check_mask(check_mask), .force_mask(force_mask),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  r, g, b;
    logic        semi, stmask;
    logic [1:0]  mode;
    logic        chk, frc;
    logic [15:0] bg;
    logic        exp_wr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one fragment through with fixed zero-wait latency plus optional stalls.
  task automatic run_vec(input vec_t v, input int rd_stall, input int wr_stall, input string nm);
    logic need_rd;
    need_rd = v.semi | v.chk;
    chk({nm, ".ready_idle"}, frag_ready, 1);
    frag_valid  = 1'b1;
    frag_addr   = v.addr;
    frag_r      = v.r;
    frag_g      = v.g;
    frag_b      = v.b;
    frag_semi   = v.semi;
    frag_stmask = v.stmask;
    blend_mode  = v.mode;
    check_mask  = v.chk;
    force_mask  = v.frc;
    tick();
    // scramble inputs after accept: the block must work from its registered copy
    frag_valid  = 1'b0;
    frag_addr   = ~v.addr;
    frag_r      = ~v.r;
    frag_g      = ~v.g;
    frag_b      = ~v.b;
    frag_semi   = ~v.semi;
    frag_stmask = ~v.stmask;
    blend_mode  = ~v.mode;
    check_mask  = ~v.chk;
    force_mask  = ~v.frc;
    chk({nm, ".busy"}, busy, 1);
    chk({nm, ".ready_busy"}, frag_ready, 0);
    if (need_rd) begin
      chk({nm, ".rd_req"}, rd_req, 1);
      chk({nm, ".rd_addr"}, rd_addr, v.addr);
      for (int i = 0; i < rd_stall; i++) begin
        tick();
        chk({nm, ".rd_req_hold"}, rd_req, 1);
        chk({nm, ".rd_addr_hold"}, rd_addr, v.addr);
        chk({nm, ".ready_rdstall"}, frag_ready, 0);
      end
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk({nm, ".rd_req_drop"}, rd_req, 0);
      rd_valid = 1'b1;
      rd_data  = v.bg;
      tick();
      rd_valid = 1'b0;
      rd_data  = ~v.bg;
    end else begin
      chk({nm, ".no_rd_req"}, rd_req, 0);
    end
    chk({nm, ".wr_req_blend"}, wr_req, 0);
    tick();
    if (v.exp_wr) begin
      chk({nm, ".wr_req"}, wr_req, 1);
      chk({nm, ".wr_addr"}, wr_addr, v.addr);
      chk({nm, ".wr_data"}, wr_data, v.exp_data);
      for (int i = 0; i < wr_stall; i++) begin
        tick();
        chk({nm, ".wr_req_hold"}, wr_req, 1);
        chk({nm, ".wr_addr_hold"}, wr_addr, v.addr);
        chk({nm, ".wr_data_hold"}, wr_data, v.exp_data);
        chk({nm, ".ready_wrstall"}, frag_ready, 0);
      end
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      chk({nm, ".wr_req_drop"}, wr_req, 0);
    end else begin
      chk({nm, ".discard_no_wr"}, wr_req, 0);
    end
    chk({nm, ".ready_done"}, frag_ready, 1);
    chk({nm, ".idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp;
    //            addr      r      g      b     semi st  mode chk frc bg        wr    data
    vecs[0]  = '{19'h00403, 8'hFF, 8'h80, 8'h08, 0, 0, 2'd0, 0, 0, 16'h0000, 1'b1, 16'h061F};
    vecs[1]  = '{19'h12345, 8'hC8, 8'h64, 8'h00, 1, 0, 2'd1, 0, 0, 16'h3DEF, 1'b1, 16'h3F7F};
    vecs[2]  = '{19'h00010, 8'hC8, 8'hC8, 8'hC8, 1, 0, 2'd2, 0, 1, 16'h3DEF, 1'b1, 16'h8000};
    vecs[3]  = '{19'h00020, 8'h11, 8'h22, 8'h33, 0, 0, 2'd0, 1, 0, 16'h8000, 1'b0, 16'h0000};
    vecs[4]  = '{19'h00C01, 8'h28, 8'h50, 8'hC8, 1, 0, 2'd0, 0, 0, 16'h3DEF, 1'b1, 16'h518A};
    vecs[5]  = '{19'h40002, 8'h40, 8'h80, 8'hFC, 1, 0, 2'd3, 0, 0, 16'h0000, 1'b1, 16'h1C82};
    vecs[6]  = '{19'h7FFFF, 8'h08, 8'h10, 8'hF8, 1, 0, 2'd2, 0, 0, 16'h7FFF, 1'b1, 16'h03BE};
    vecs[7]  = '{19'h00805, 8'h0A, 8'h14, 8'h1E, 1, 1, 2'd1, 1, 0, 16'h0421, 1'b1, 16'h9062};
    vecs[8]  = '{19'h00030, 8'h80, 8'h80, 8'h80, 1, 0, 2'd1, 1, 0, 16'hFFFF, 1'b0, 16'h0000};
    vecs[9]  = '{19'h00040, 8'hFF, 8'h80, 8'h08, 0, 0, 2'd2, 1, 1, 16'h0000, 1'b1, 16'h861F};
    vecs[10] = '{19'h00050, 8'hFF, 8'hFF, 8'hFF, 1, 0, 2'd0, 0, 0, 16'h8000, 1'b1, 16'h3DEF};

    rst = 1'b1;
    frag_valid = 0; frag_addr = '0; frag_r = 0; frag_g = 0; frag_b = 0;
    frag_semi = 0; frag_stmask = 0; blend_mode = 0; check_mask = 0; force_mask = 0;
    rd_ack = 0; rd_valid = 0; rd_data = '0; wr_ack = 0;

    // reset state
    tick();
    tick();
    chk("rst.frag_ready", frag_ready, 0);
    chk("rst.rd_req", rd_req, 0);
    chk("rst.wr_req", wr_req, 0);
    chk("rst.rd_addr", rd_addr, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);
    chk("rst.busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("rel.frag_ready", frag_ready, 1);

    for (int i = 0; i < 11; i++)
      run_vec(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // backpressure: rd_ack held low 5 cycles, wr_ack held low 3 cycles
    bp = vecs[1];
    bp.addr = 19'h2ABCD;
    run_vec(bp, 5, 3, "bp");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp.single_write", wr_req, 0);
    end

    // reset while waiting for read data
    frag_valid = 1'b1; frag_addr = 19'h01234; frag_r = 8'h10; frag_g = 8'h20; frag_b = 8'h30;
    frag_semi = 1'b1; frag_stmask = 1'b1; blend_mode = 2'd1; check_mask = 1'b0; force_mask = 1'b1;
    tick();
    frag_valid = 1'b0;
    chk("mid.rd_req", rd_req, 1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    chk("mid.busy_rdwait", busy, 1);
    rst = 1'b1;
    rd_valid = 1'b1;
    rd_data = 16'h1234;
    #1;
    chk("mid.rd_req", rd_req, 0);
    chk("mid.wr_req", wr_req, 0);
    chk("mid.rd_addr", rd_addr, 0);
    chk("mid.wr_addr", wr_addr, 0);
    chk("mid.wr_data", wr_data, 0);
    chk("mid.busy", busy, 0);
    chk("mid.frag_ready", frag_ready, 0);
    tick();
    chk("mid.ready_in_rst", frag_ready, 0);
    rst = 1'b0;
    rd_valid = 1'b0;
    tick();
    chk("mid.ready_after", frag_ready, 1);
    chk("mid.no_write", wr_req, 0);
    tick();
    chk("mid.still_idle", busy, 0);
    run_vec(vecs[0], 0, 0, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
